sample_feeder: RTL

//  Transmit side of the rolling-average sample interface: buffers up to DEPTH samples,

---
 rtl/rolling_avg_pkg.sv | 27 ++
 rtl/sample_feeder_phase_timer.sv | 30 +++
 rtl/sample_feeder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rolling_avg_pkg.sv
// Shared types and helpers for the rolling-average sample interface.
// Holds the feeder FSM encoding and the phase-timer width calculation.
package rolling_avg_pkg;

  localparam int DEF_BITS_PER_ELEM = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_GAP   = 2'd3
  } feeder_state_t;

  // The timer holds (cycles - 1), so the widest phase sets the counter width.
  function automatic int timer_width(input int setup_cyc, input int high_cyc, input int gap_cyc);
    int max_cyc;
    max_cyc = setup_cyc;
    if (high_cyc > max_cyc) begin
      max_cyc = high_cyc;
    end
    if (gap_cyc > max_cyc) begin
      max_cyc = gap_cyc;
    end
    return (max_cyc > 1) ? $clog2(max_cyc) : 1;
  endfunction

endpackage

// File: rtl/sample_feeder_phase_timer.sv
// Loadable down-counter that times each strobe phase of the sample feeder.
// tc is high while the count sits at zero, i.e. in the last cycle of a phase.
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_r;

  // Reload on every phase change, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {W{1'b0}}) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/sample_feeder.sv
// Transmit side of the rolling-average sample interface: buffers samples and
// replays them as a value bus plus a data strobe with programmable timing.
module sample_feeder
  import rolling_avg_pkg::*;
#(
  parameter int BITS_PER_ELEM = DEF_BITS_PER_ELEM,
  parameter int DEPTH         = 8,
  parameter int SETUP_CYC     = 1,
  parameter int HIGH_CYC      = 2,
  parameter int GAP_CYC       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [BITS_PER_ELEM-1:0] i_wr_value,
  input  logic                     i_clear,
  input  logic                     i_start,
  input  logic                     i_loop,
  input  logic                     i_stop,
  output logic [BITS_PER_ELEM-1:0] o_value,
  output logic                     o_data_clk,
  output logic                     o_busy,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = timer_width(SETUP_CYC, HIGH_CYC, GAP_CYC);

  feeder_state_t state_r;
  feeder_state_t state_s;

  logic [BITS_PER_ELEM-1:0] mem_r [DEPTH];
  logic [CW-1:0]            count_r;
  logic [CW-1:0]            count_nxt_s;
  logic [PW-1:0]            wr_ptr_r;
  logic [PW-1:0]            rd_ptr_r;
  logic                     loop_r;
  logic                     stop_r;

  logic [BITS_PER_ELEM-1:0] value_r;
  logic                     data_clk_r;
  logic                     busy_r;
  logic                     full_r;
  logic                     empty_r;
  logic                     done_r;

  logic                     load_s;
  logic [TW-1:0]            load_val_s;
  logic                     tc_s;
  logic                     start_s;
  logic                     advance_s;
  logic                     wrap_s;
  logic                     finish_s;
  logic                     wr_s;
  logic                     clr_s;
  logic                     is_last_s;

  phase_timer #(
    .W(TW)
  ) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .load_val(load_val_s),
    .tc      (tc_s)
  );

  assign is_last_s = ({1'b0, rd_ptr_r} == (count_r - CW'(1)));

  // Next-state logic: phase sequencing, frame advance, wrap and termination.
  always_comb begin
    state_s    = state_r;
    load_s     = 1'b0;
    load_val_s = {TW{1'b0}};
    start_s    = 1'b0;
    advance_s  = 1'b0;
    wrap_s     = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start && (count_r != {CW{1'b0}})) begin
          state_s    = ST_SETUP;
          load_s     = 1'b1;
          load_val_s = TW'(SETUP_CYC - 1);
          start_s    = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tc_s) begin
          state_s    = ST_HIGH;
          load_s     = 1'b1;
          load_val_s = TW'(HIGH_CYC - 1);
        end else begin
          state_s = ST_SETUP;
        end
      end
      ST_HIGH: begin
        if (tc_s) begin
          state_s    = ST_GAP;
          load_s     = 1'b1;
          load_val_s = TW'(GAP_CYC - 1);
        end else begin
          state_s = ST_HIGH;
        end
      end
      ST_GAP: begin
        if (!tc_s) begin
          state_s = ST_GAP;
        end else if (stop_r || i_stop) begin
          state_s  = ST_IDLE;
          finish_s = 1'b1;
        end else if (!is_last_s) begin
          state_s    = ST_SETUP;
          load_s     = 1'b1;
          load_val_s = TW'(SETUP_CYC - 1);
          advance_s  = 1'b1;
        end else if (loop_r) begin
          state_s    = ST_SETUP;
          load_s     = 1'b1;
          load_val_s = TW'(SETUP_CYC - 1);
          wrap_s     = 1'b1;
        end else begin
          state_s  = ST_IDLE;
          finish_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Buffer bookkeeping is only open in IDLE; an accepted start blocks write and clear.
  always_comb begin
    clr_s       = 1'b0;
    wr_s        = 1'b0;
    count_nxt_s = count_r;
    if ((state_r == ST_IDLE) && !start_s) begin
      clr_s = i_clear;
      wr_s  = !i_clear && i_wr_en && (count_r != CW'(DEPTH));
    end else begin
      clr_s = 1'b0;
      wr_s  = 1'b0;
    end
    if (clr_s) begin
      count_nxt_s = {CW{1'b0}};
    end else if (wr_s) begin
      count_nxt_s = count_r + CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Sample storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= i_wr_value;
    end
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      count_r    <= {CW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      loop_r     <= 1'b0;
      stop_r     <= 1'b0;
      value_r    <= {BITS_PER_ELEM{1'b0}};
      data_clk_r <= 1'b0;
      busy_r     <= 1'b0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_nxt_s;
      full_r     <= (count_nxt_s == CW'(DEPTH));
      empty_r    <= (count_nxt_s == {CW{1'b0}});
      data_clk_r <= (state_s == ST_HIGH);
      done_r     <= finish_s;

      if (clr_s) begin
        wr_ptr_r <= {PW{1'b0}};
      end else if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end

      if (start_s) begin
        stop_r <= 1'b0;
      end else if ((state_r != ST_IDLE) && i_stop) begin
        stop_r <= 1'b1;
      end

      if (start_s) begin
        rd_ptr_r <= {PW{1'b0}};
        loop_r   <= i_loop;
        value_r  <= mem_r[0];
        busy_r   <= 1'b1;
      end else if (advance_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
        value_r  <= mem_r[rd_ptr_r + PW'(1)];
      end else if (wrap_s) begin
        rd_ptr_r <= {PW{1'b0}};
        value_r  <= mem_r[0];
      end else if (finish_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  assign o_value    = value_r;
  assign o_data_clk = data_clk_r;
  assign o_busy     = busy_r;
  assign o_full     = full_r;
  assign o_empty    = empty_r;
  assign o_done     = done_r;

endmodule
